// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and stream framing constants.
package riscv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR0  = 3'd1,
    ST_HDR1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_CSUM  = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } loader_state_t;

  // Bytes per instruction word and bytes in the word-count header.
  localparam int IMEM_WORD_BYTES  = 4;
  localparam int LOADER_HDR_BYTES = 2;

  // States in which a new load session may be started.
  function automatic logic is_start_state(loader_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word packer. Each push shifts the byte into the top
// lane so that after four pushes the first byte sits in bits [7:0]. `full`
// flags the push that completes a word; `word_next` is the packed value
// including the byte being pushed this cycle.
module word_assembler
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic        full,
  output logic [31:0] word_next
);

  localparam int IDX_W = $clog2(IMEM_WORD_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMEM_WORD_BYTES - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      pack_q, pack_d;

  // Next byte index and pack contents; clr wins over push.
  always_comb begin
    idx_d  = idx_q;
    pack_d = pack_q;
    if (clr) begin
      idx_d  = '0;
      pack_d = '0;
    end else if (push) begin
      idx_d  = idx_q + IDX_W'(1);
      pack_d = {byte_in, pack_q[31:8]};
    end
  end

  assign full      = push && !clr && (idx_q == LAST_IDX);
  assign word_next = pack_d;

  // Index and pack register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      pack_q <= '0;
    end else begin
      idx_q  <= idx_d;
      pack_q <= pack_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader. Receives a byte stream (16-bit
// little-endian word count, then 4N data bytes), packs the bytes into 32-bit
// words and writes them to consecutive addresses from BASE_ADDR while holding
// the core stalled. Every output is a flop computed from the next state.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing 8-bit
// checksum byte that must match the sum of all data bytes.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  // Largest word count the memory can hold.
  localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t ST_FINISH = ST_CSUM;
`else
  localparam loader_state_t ST_FINISH = ST_DONE;
`endif

  loader_state_t state_q, state_d;
  logic [15:0]   n_q, n_d;
  logic [15:0]   word_idx_q, word_idx_d;
  logic          byte_ready_q, byte_ready_d;
  logic          imem_we_q, imem_we_d;
  logic [31:0]   imem_addr_q, imem_addr_d;
  logic [31:0]   imem_wdata_q, imem_wdata_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic          xfer;
  logic [15:0]   hdr_n;
  logic          asm_clr;
  logic          asm_push;
  logic          asm_full;
  logic [31:0]   asm_word;

  assign xfer  = byte_valid && byte_ready_q;
  assign hdr_n = {byte_data, n_q[7:0]};

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (asm_clr),
    .push      (asm_push),
    .byte_in   (byte_data),
    .full      (asm_full),
    .word_next (asm_word)
  );

  // Next-state logic; registered outputs are decoded from the next state so
  // they line up with the state they describe.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    word_idx_d   = word_idx_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    asm_clr      = 1'b0;
    asm_push     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_HDR0;
          n_d        = '0;
          word_idx_d = '0;
          asm_clr    = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      ST_HDR0: begin
        if (xfer) begin
          n_d[7:0] = byte_data;
          state_d  = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (xfer) begin
          n_d = hdr_n;
          if (hdr_n == 16'd0)                 state_d = ST_FINISH;
          else if ({17'd0, hdr_n} > CAPACITY) state_d = ST_ERR;
          else                                state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          asm_push = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d   = csum_q + byte_data;
`endif
          if (asm_full) begin
            state_d      = ST_WRITE;
            imem_addr_d  = BASE_ADDR + 32'({word_idx_q, 2'b00});
            imem_wdata_d = asm_word;
          end
        end
      end
      ST_WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
        if ((17'(word_idx_q) + 17'd1) < 17'(n_q)) state_d = ST_DATA;
        else                                      state_d = ST_FINISH;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (xfer) state_d = (byte_data == csum_q) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    byte_ready_d = (state_d == ST_HDR0) || (state_d == ST_HDR1) ||
                   (state_d == ST_DATA) || (state_d == ST_CSUM);
    imem_we_d    = (state_d == ST_WRITE);
    cpu_hold_d   = !is_start_state(state_d);
    done_d       = (state_d == ST_DONE);
    error_d      = (state_d == ST_ERR);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      word_idx_q   <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      word_idx_q   <= word_idx_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer: accepts a little-endian byte stream over a valid/ready handshake, packs bytes into 32-bit words, and writes them sequentially into the instruction memory that the fetch stage reads. While loading it holds the core stalled via `cpu_hold`, then releases it with `done`. It is the write side of the fetch unit's instruction-memory interface.

## Interface
- `ADDR_WIDTH`, 10: word-address width of instruction memory; capacity is 2^ADDR_WIDTH words.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first written word; must be 4-byte aligned.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  begin a load session; sampled only in IDLE, DONE, ERR.
- `byte_valid`  in  1  stream byte present.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  one-cycle write strobe to instruction memory.
- `imem_addr`  out  32  byte address of write.
- `imem_wdata`  out  32  write data.
- `cpu_hold`  out  1  stall/flush request to the core while loading.
- `done`  out  1  load completed successfully; level, held until next `start`.
- `error`  out  1  load aborted; level, held until next `start`.

## Operation
- Transfer occurs on a rising edge with `byte_valid && byte_ready`; no transfer otherwise, loader waits indefinitely.
- Stream format: header byte 0 = word count N[7:0], header byte 1 = N[15:8]; then 4N data bytes, first byte of each word into bits [7:0], fourth into [31:24].
- States: IDLE, HDR0, HDR1, DATA, WRITE, (CSUM), DONE, ERR.
- IDLE/DONE/ERR --start--> HDR0; clears `done`, `error`, word index, byte index; sets `cpu_hold`.
- HDR0 --byte--> HDR1; HDR1 --byte--> DATA if 0 < N <= 2^ADDR_WIDTH; N == 0 -> DONE (or CSUM); N > 2^ADDR_WIDTH -> ERR, no writes.
- DATA: accept bytes into shift/pack register; on 4th byte -> WRITE.
- WRITE: `imem_we`=1 for exactly one cycle, `imem_addr` = BASE_ADDR + 4*word_idx (32-bit, wraps mod 2^32), `imem_wdata` = packed word; word_idx++; next DATA if word_idx+1 < N else DONE (or CSUM).
- DONE: `done`=1, `cpu_hold`=0. ERR: `error`=1, `cpu_hold`=0, `byte_ready`=0; extra stream bytes not consumed.
- `byte_ready`=1 only in HDR0, HDR1, DATA, CSUM.
- `start` outside IDLE/DONE/ERR ignored.

## Timing
- Reset values: `byte_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `cpu_hold` 0, `done` 0, `error` 0; state IDLE.
- All outputs registered. `start` sampled at edge k -> `cpu_hold`=1, `byte_ready`=1 in cycle k+1.
- 4th byte of a word accepted at edge k -> `imem_we`=1 in cycle k+1, `byte_ready`=0 in that cycle; `byte_ready` returns in k+2 if more data.
- Minimum session: 2 + 5N cycles after start (no checksum) with `byte_valid` held high.
- Final write cycle k -> `done`=1 and `cpu_hold`=0 together in cycle k+1.
- `rst` mid-session: all outputs to reset values at the next edge; partial word discarded; already-written words remain in memory.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: after last word (or N==0), CSUM state accepts one byte; must equal 8-bit sum mod 256 of all data bytes (header excluded); match -> DONE, mismatch -> ERR. Words are still written before the check.
- Undefined: no CSUM state; WRITE of last word (or HDR1 with N==0) goes directly to DONE.

## Structure
- Shared package `riscv_pkg`: `loader_state_t` enum, `IMEM_WORD_BYTES` = 4, `LOADER_HDR_BYTES` = 2.
- One sub-module `word_assembler`: byte index counter plus 32-bit little-endian pack register, `clr` and `push` inputs, `full` output.

## Test plan
- Header 02 00, bytes 13 00 00 00 93 00 10 00, BASE_ADDR 0 -> writes 0x00000013 @0x0, 0x00100093 @0x4; `done`=1, `cpu_hold`=0 next cycle.
- `byte_valid` toggled every other cycle, N=1, bytes EF BE AD DE -> single write 0xDEADBEEF, exactly one `imem_we` pulse.
- Header 00 00 -> no `imem_we`, `done`=1 (checksum on: byte 00 required first).
- ADDR_WIDTH=4, header 11 00 (N=17) -> `error`=1, no writes, `byte_ready`=0.
- `rst` after 2 data bytes of word 0 -> all outputs 0 next cycle; new `start` with N=1 writes full fresh word at BASE_ADDR.
- Checksum on, N=1, bytes 01 02 03 04, checksum 0A -> `done`; checksum 0B -> `error`, word still written.
